demux_1to4_stream: RTL and testbench

//   Registered 1-to-4 stream demultiplexer; inverse of the team's 4:1 mux datapath.

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_slot.sv | 85 ++++++++
 rtl/demux_1to4_stream.sv | 58 +++++
 tb/tb_demux_1to4_stream.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
// Optional feature macro: DEMUX_STATS_EN (per-channel delivered-word counters).
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot for a single demux output channel.
// A word is held until its consumer takes it; a new word may be written in the
// same cycle the old one drains, so a channel sustains one word per cycle.
// Optional feature macro: DEMUX_STATS_EN adds a wrapping count of drained words.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_t state;
    slot_state_t state_next;
    logic        drain;

    // Reject parameter values that would leave a zero-width datapath or counter.
    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
        $error("demux_slot: WIDTH and CNT_W must be at least 1");
    end

    assign valid = (state == SLOT_FULL);
    assign drain = valid & drain_ready;

    // Slot occupancy register; reset empties the slot immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy transitions: a load always leaves the slot full, a drain without a load empties it.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (drain && !load) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: begin
                state_next = SLOT_EMPTY;
            end
        endcase
    end

    // Data is only written on a load, so a stalled word stays stable until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

`ifdef DEMUX_STATS_EN
    // Count words handed to the consumer; wraps naturally at 2**CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with valid/ready flow control.
// Each channel owns a one-entry slot, so a stalled consumer only stalls words
// addressed to it. Acceptance depends solely on the currently selected slot.
// Optional feature macro: DEMUX_STATS_EN adds the out_cnt per-channel counters.
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*WIDTH-1:0]  out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]  out_cnt
`endif
);

    logic [NUM_CH-1:0] load;

    // A word can enter when its target slot is empty or is being emptied this cycle.
    assign in_ready = !out_valid[in_sel] | out_ready[in_sel];

    // Decode the destination so that at most one slot loads per cycle.
    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (load[k]),
            .load_data   (in_data),
            .drain_ready (out_ready[k]),
            .data        (out_data[k*WIDTH +: WIDTH]),
            .valid       (out_valid[k])
`ifdef DEMUX_STATS_EN
            ,
            .cnt         (out_cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream: directed vector table, hand-written
// reset sequences and randomized traffic against a channel-level reference model.
// Optional feature macro: DEMUX_STATS_EN enables the counter checks.
module tb_demux_1to4_stream;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  in_data;
    logic [1:0]        in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
`ifdef DEMUX_STATS_EN
    logic [4*CNT_W-1:0] out_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: what each channel currently holds and how many words it delivered.
    logic [3:0]       mv;
    logic [WIDTH-1:0] md [4];
    int               mcnt [4];

    typedef struct {
        logic [3:0] d;
        logic [1:0] s;
        logic       v;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic [1:0] ch;
        logic [3:0] exp_d;
    } vec_t;

    vec_t vecs [11];

    demux_1to4_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d, input logic [1:0] s,
                                 input logic v, input logic [3:0] ordy);
        in_data   = d;
        in_sel    = s;
        in_valid  = v;
        out_ready = ordy;
    endtask

    task automatic modelClear();
        mv = '0;
        for (int k = 0; k < 4; k++) begin
            md[k]   = '0;
            mcnt[k] = 0;
        end
    endtask

    function automatic logic modelReady(input logic [1:0] s, input logic [3:0] r);
        return !mv[s] || r[s];
    endfunction

    // One clock: advance the model by the transfers the spec allows, then settle at the negedge.
    task automatic tick();
        logic       acc;
        logic [1:0] s;
        logic [3:0] d;
        logic [3:0] r;
        acc = in_valid && modelReady(in_sel, out_ready);
        s   = in_sel;
        d   = in_data;
        r   = out_ready;
        @(posedge clk);
        if (!rst_n) begin
            modelClear();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (mv[k] && r[k]) begin
                    mv[k]   = 1'b0;
                    mcnt[k] = (mcnt[k] + 1) % (1 << CNT_W);
                end
            end
            if (acc) begin
                mv[s] = 1'b1;
                md[s] = d;
            end
        end
        @(negedge clk);
    endtask

    // Compare every observable output against the model for the current inputs.
    task automatic checkModel(input string tag);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(modelReady(in_sel, out_ready)));
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(mv));
        for (int k = 0; k < 4; k++) begin
            if (mv[k]) begin
                checkOutput($sformatf("%s out_data[%0d]", tag, k),
                            32'(out_data[k*WIDTH +: WIDTH]), 32'(md[k]));
            end
`ifdef DEMUX_STATS_EN
            checkOutput($sformatf("%s out_cnt[%0d]", tag, k),
                        32'(out_cnt[k*CNT_W +: CNT_W]), 32'(mcnt[k]));
`endif
        end
    endtask

    initial begin
        // Directed sequence: routing, backpressure isolation, load+drain.
        vecs[0]  = '{4'h3, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'h3};
        vecs[1]  = '{4'hA, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 4'hA};
        vecs[2]  = '{4'h5, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 4'h5};
        vecs[3]  = '{4'hC, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 4'hC};
        vecs[4]  = '{4'h7, 2'd2, 1'b1, 4'b1011, 1'b1, 4'b0100, 2'd2, 4'h7};
        vecs[5]  = '{4'h9, 2'd2, 1'b1, 4'b1011, 1'b0, 4'b0100, 2'd2, 4'h7};
        vecs[6]  = '{4'h1, 2'd0, 1'b1, 4'b1011, 1'b1, 4'b0101, 2'd0, 4'h1};
        vecs[7]  = '{4'hF, 2'd2, 1'b0, 4'b1010, 1'b0, 4'b0101, 2'd2, 4'h7};
        vecs[8]  = '{4'hE, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0111, 2'd1, 4'hE};
        vecs[9]  = '{4'h4, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b0111, 2'd1, 4'h4};
        vecs[10] = '{4'h0, 2'd1, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1, 4'h4};

        modelClear();
        rst_n = 1'b0;
        applyStimulus(4'h0, 2'd0, 1'b0, 4'b0000);

        // Reset with random inputs: everything empty and ready.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
            tick();
            checkOutput("reset out_valid", 32'(out_valid), 32'h0);
            checkOutput("reset in_ready", 32'(in_ready), 32'h1);
            checkOutput("reset out_data", 32'(out_data), 32'h0);
`ifdef DEMUX_STATS_EN
            checkOutput("reset out_cnt", 32'(out_cnt), 32'h0);
`endif
        end
        applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].d, vecs[i].s, vecs[i].v, vecs[i].ordy);
            #1;
            checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            tick();
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            checkOutput($sformatf("vec%0d out_data[%0d]", i, vecs[i].ch),
                        32'(out_data[vecs[i].ch*WIDTH +: WIDTH]), 32'(vecs[i].exp_d));
        end

        // Reset between edges while slots 0 and 3 hold unconsumed words.
        applyStimulus(4'h6, 2'd0, 1'b1, 4'b0000);
        tick();
        applyStimulus(4'hB, 2'd3, 1'b1, 4'b0000);
        tick();
        checkOutput("midreset before out_valid", 32'(out_valid), 32'b1001);
        applyStimulus(4'h0, 2'd0, 1'b0, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset async out_valid", 32'(out_valid), 32'h0);
        modelClear();
        #1 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("postreset out_valid", 32'(out_valid), 32'h0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                          4'($urandom) | 4'($urandom));
            #1;
            checkModel("rand");
            tick();
        end
        applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111);
        tick();
        checkModel("rand flush");

`ifdef DEMUX_STATS_EN
        // Counter wrap: 257 deliveries on channel 3 leave it at 1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 257; i++) begin
            applyStimulus(4'($urandom), 2'd3, 1'b1, 4'b1111);
            tick();
        end
        applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111);
        tick();
        checkOutput("wrap out_cnt[3]", 32'(out_cnt[3*CNT_W +: CNT_W]), 32'd1);
        checkOutput("wrap out_cnt[2:0]", 32'(out_cnt[3*CNT_W-1:0]), 32'h0);
        checkModel("wrap");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
